rx_medidas_7e1: RTL and testbench

Receiving end of the 7E1 distance-telemetry link. Deserialises the asynchronous 7E1 stream and checks parity and stop bit. Parses the 12-character burst "d2 d1 d0 #" for sensor 1, then sensor 2, then sensor 3. Publishes the three 12-bit nibble-packed measurements atomically. Sits on the host/companion FPGA side, fed directly from the UART pin.

---
 rtl/rx_medidas_pkg.sv | 29 ++
 rtl/rx_serial_7e1.sv | 137 +++++++++++++
 rtl/rx_medidas_7e1.sv | 141 ++++++++++++++
 tb/tb_rx_medidas_7e1.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rx_medidas_pkg.sv
// Shared encodings and constants for the 7E1 distance-telemetry receiver.
package rx_medidas_pkg;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        INICIO   = 3'd1,
        DADOS    = 3'd2,
        PARIDADE = 3'd3,
        PARADA   = 3'd4,
        BREAK    = 3'd5
    } rx_estado_t;

    typedef enum logic [1:0] {
        ESPERA_DIGITO    = 2'd0,
        ESPERA_CERQUILHA = 2'd1,
        DESCARTA         = 2'd2
    } parser_estado_t;

    localparam logic [6:0]  ASCII_CERQUILHA = 7'h23;
    localparam logic [2:0]  PREFIXO_DIGITO  = 3'b011;
    localparam int unsigned N_GRUPOS        = 3;
    localparam int unsigned N_DIGITOS       = 3;

    // Digits are any character in 0x30..0x3F; the low nibble is kept raw.
    function automatic logic eh_digito(input logic [6:0] c);
        return c[6:4] == PREFIXO_DIGITO;
    endfunction

endpackage

// File: rtl/rx_serial_7e1.sv
// 7E1 UART deserialiser: input synchroniser, mid-bit sampling, parity and stop checks.
module rx_serial_7e1
    import rx_medidas_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    output logic [6:0] dados,
    output logic       char_ok,
    output logic       erro_paridade,
    output logic       erro_quadro,
    output logic       ocioso,
    output rx_estado_t estado
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] FIM_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] MEIO_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             sinc_a, linha;
    rx_estado_t       estado_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       n_bits, n_bits_d;
    logic [6:0]       sr, sr_d;
    logic             par, par_d;
    logic             char_ok_d, erro_paridade_d, erro_quadro_d;
    logic             fim;

    // Two-flop synchroniser; reset to the idle (high) line level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinc_a <= 1'b1;
            linha  <= 1'b1;
        end else begin
            sinc_a <= entrada_serial;
            linha  <= sinc_a;
        end
    end

    assign fim = (cnt == FIM_BIT);

    always_comb begin
        estado_d        = estado;
        cnt_d           = cnt;
        n_bits_d        = n_bits;
        sr_d            = sr;
        par_d           = par;
        char_ok_d       = 1'b0;
        erro_paridade_d = 1'b0;
        erro_quadro_d   = 1'b0;
        case (estado)
            OCIOSO: begin
                if (!linha) begin
                    estado_d = INICIO;
                    cnt_d    = '0;
                    n_bits_d = '0;
                end
            end
            INICIO: begin
                if (cnt == MEIO_BIT) begin
                    cnt_d    = '0;
                    estado_d = linha ? OCIOSO : DADOS;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DADOS: begin
                if (fim) begin
                    cnt_d    = '0;
                    sr_d     = {linha, sr[6:1]};
                    n_bits_d = n_bits + 3'd1;
                    if (n_bits == 3'd6) estado_d = PARIDADE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            PARIDADE: begin
                if (fim) begin
                    cnt_d    = '0;
                    par_d    = linha;
                    estado_d = PARADA;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            PARADA: begin
                if (fim) begin
                    cnt_d = '0;
                    if (linha) begin
                        estado_d = OCIOSO;
                        if (^{sr, par}) erro_paridade_d = 1'b1;
                        else            char_ok_d       = 1'b1;
                    end else begin
                        // Framing error wins over parity; wait out the low line.
                        erro_quadro_d = 1'b1;
                        estado_d      = BREAK;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            BREAK: begin
                if (linha) estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado        <= OCIOSO;
            cnt           <= '0;
            n_bits        <= '0;
            sr            <= '0;
            par           <= 1'b0;
            dados         <= '0;
            char_ok       <= 1'b0;
            erro_paridade <= 1'b0;
            erro_quadro   <= 1'b0;
            ocioso        <= 1'b1;
        end else begin
            estado        <= estado_d;
            cnt           <= cnt_d;
            n_bits        <= n_bits_d;
            sr            <= sr_d;
            par           <= par_d;
            char_ok       <= char_ok_d;
            erro_paridade <= erro_paridade_d;
            erro_quadro   <= erro_quadro_d;
            ocioso        <= (estado_d == OCIOSO);
            if (char_ok_d) dados <= sr;
        end
    end

endmodule

// File: rtl/rx_medidas_7e1.sv
// Telemetry receiver top: parses "d2 d1 d0 #" x3 bursts and publishes the three measurements atomically.
module rx_medidas_7e1
    import rx_medidas_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned IDLE_CLKS    = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [11:0] medida1,
    output logic [11:0] medida2,
    output logic [11:0] medida3,
    output logic        pronto,
    output logic [6:0]  dados_ascii,
    output logic        caractere_pronto,
    output logic        erro_paridade,
    output logic        erro_quadro,
    output logic        erro_formato,
    output logic [3:0]  db_estado
);

    localparam int unsigned IDLE_W = $clog2(IDLE_CLKS + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CLKS);

    logic           char_ok, ocioso;
    logic [6:0]     dados;
    rx_estado_t     rx_estado;

    parser_estado_t parser, parser_d;
    logic [1:0]     grupo, grupo_d, indice, indice_d;
    logic [11:0]    sombra   [N_GRUPOS];
    logic [11:0]    sombra_d [N_GRUPOS];
    logic           publica_d, formato_d;
    logic [IDLE_W-1:0] ocioso_cnt;
    logic           ocioso_cheio;

    rx_serial_7e1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock         (clock),
        .reset         (reset),
        .entrada_serial(entrada_serial),
        .dados         (dados),
        .char_ok       (char_ok),
        .erro_paridade (erro_paridade),
        .erro_quadro   (erro_quadro),
        .ocioso        (ocioso),
        .estado        (rx_estado)
    );

    assign dados_ascii      = dados;
    assign caractere_pronto = char_ok;
    assign db_estado        = {parser, rx_estado[1:0]};

    // Idle-line counter; leaving OCIOSO (start-bit detection) clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                       ocioso_cnt <= '0;
        else if (!ocioso)                ocioso_cnt <= '0;
        else if (ocioso_cnt != IDLE_MAX) ocioso_cnt <= ocioso_cnt + IDLE_W'(1);
    end

    assign ocioso_cheio = (ocioso_cnt == IDLE_MAX);

    always_comb begin
        parser_d  = parser;
        grupo_d   = grupo;
        indice_d  = indice;
        sombra_d  = sombra;
        publica_d = 1'b0;
        formato_d = 1'b0;
        if (ocioso_cheio) begin
            parser_d = ESPERA_DIGITO;
            grupo_d  = '0;
            indice_d = '0;
        end else if (erro_paridade || erro_quadro) begin
            parser_d = DESCARTA;
        end else if (char_ok) begin
            case (parser)
                ESPERA_DIGITO: begin
                    if (eh_digito(dados)) begin
                        case (indice)
                            2'd0:    sombra_d[grupo][11:8] = dados[3:0];
                            2'd1:    sombra_d[grupo][7:4]  = dados[3:0];
                            default: sombra_d[grupo][3:0]  = dados[3:0];
                        endcase
                        indice_d = indice + 2'd1;
                        if (indice == 2'(N_DIGITOS - 1)) parser_d = ESPERA_CERQUILHA;
                    end else begin
                        formato_d = 1'b1;
                        parser_d  = DESCARTA;
                    end
                end
                ESPERA_CERQUILHA: begin
                    if (dados == ASCII_CERQUILHA) begin
                        indice_d = '0;
                        parser_d = ESPERA_DIGITO;
                        if (grupo == 2'(N_GRUPOS - 1)) begin
                            publica_d = 1'b1;
                            grupo_d   = '0;
                        end else begin
                            grupo_d = grupo + 2'd1;
                        end
                    end else begin
                        formato_d = 1'b1;
                        parser_d  = DESCARTA;
                    end
                end
                default: parser_d = DESCARTA;
            endcase
        end
    end

    // Measurements only ever load together, from a complete burst.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parser       <= ESPERA_DIGITO;
            grupo        <= '0;
            indice       <= '0;
            sombra       <= '{default: '0};
            medida1      <= '0;
            medida2      <= '0;
            medida3      <= '0;
            pronto       <= 1'b0;
            erro_formato <= 1'b0;
        end else begin
            parser       <= parser_d;
            grupo        <= grupo_d;
            indice       <= indice_d;
            sombra       <= sombra_d;
            pronto       <= publica_d;
            erro_formato <= formato_d;
            if (publica_d) begin
                medida1 <= sombra[0];
                medida2 <= sombra[1];
                medida3 <= sombra[2];
            end
        end
    end

endmodule

// File: tb/tb_rx_medidas_7e1.sv
// Directed bench for rx_medidas_7e1 with CLKS_PER_BIT=8, IDLE_CLKS=200.
module tb_rx_medidas_7e1;

    localparam int unsigned CPB  = 8;
    localparam int unsigned IDLE = 200;

    logic        clock = 1'b0;
    logic        reset;
    logic        linha;
    logic [11:0] medida1, medida2, medida3;
    logic        pronto;
    logic [6:0]  dados_ascii;
    logic        caractere_pronto, erro_paridade, erro_quadro, erro_formato;
    logic [3:0]  db_estado;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0, c_char = 0, c_pronto = 0, c_par = 0, c_qua = 0, c_fmt = 0;
    int last_char_cyc = 0, last_pronto_cyc = 0;
    int b_char, b_pronto, b_par, b_qua, b_fmt;

    rx_medidas_7e1 #(
        .CLKS_PER_BIT(CPB),
        .IDLE_CLKS   (IDLE)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .entrada_serial  (linha),
        .medida1         (medida1),
        .medida2         (medida2),
        .medida3         (medida3),
        .pronto          (pronto),
        .dados_ascii     (dados_ascii),
        .caractere_pronto(caractere_pronto),
        .erro_paridade   (erro_paridade),
        .erro_quadro     (erro_quadro),
        .erro_formato    (erro_formato),
        .db_estado       (db_estado)
    );

    always #5 clock = ~clock;

    // Pulse counters, sampled on the inactive edge.
    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (caractere_pronto) begin
            c_char        <= c_char + 1;
            last_char_cyc <= cyc;
        end
        if (pronto) begin
            c_pronto        <= c_pronto + 1;
            last_pronto_cyc <= cyc;
        end
        if (erro_paridade) c_par <= c_par + 1;
        if (erro_quadro)   c_qua <= c_qua + 1;
        if (erro_formato)  c_fmt <= c_fmt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_char = c_char; b_pronto = c_pronto; b_par = c_par; b_qua = c_qua; b_fmt = c_fmt;
    endtask

    task automatic bit_period(input logic v);
        linha = v;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic idle(input int n);
        linha = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    // A frame with a 0 stop bit leaves the line low for the caller to release.
    task automatic send_char(input logic [6:0] c, input logic flip_par, input logic stop);
        bit_period(1'b0);
        for (int i = 0; i < 7; i++) bit_period(c[i]);
        bit_period((^c) ^ flip_par);
        bit_period(stop);
        if (stop) idle(4);
    endtask

    task automatic send_burst(input string s, input int par_idx);
        for (int i = 0; i < s.len(); i++) send_char(7'(s[i]), (i == par_idx), 1'b1);
        idle(10);
    endtask

    task automatic check_medidas(input string tag, input logic [11:0] e1, input logic [11:0] e2,
                                 input logic [11:0] e3);
        check_eq({tag, "_m1"}, 32'(medida1), 32'(e1));
        check_eq({tag, "_m2"}, 32'(medida2), 32'(e2));
        check_eq({tag, "_m3"}, 32'(medida3), 32'(e3));
    endtask

    initial begin
        string s4;
        reset = 1'b1;
        linha = 1'b1;
        repeat (3) @(negedge clock);
        check_medidas("reset", 12'h000, 12'h000, 12'h000);
        check_eq("reset_pronto", 32'(pronto), 32'd0);
        check_eq("reset_ascii", 32'(dados_ascii), 32'd0);
        check_eq("reset_db", 32'(db_estado), 32'd0);
        reset = 1'b0;
        idle(20);

        // Nominal burst.
        snap();
        send_burst("123#456#789#", -1);
        check_medidas("nominal", 12'h123, 12'h456, 12'h789);
        check_eq("nominal_pronto", 32'(c_pronto - b_pronto), 32'd1);
        check_eq("nominal_chars", 32'(c_char - b_char), 32'd12);
        check_eq("nominal_errs", 32'(c_par - b_par + c_qua - b_qua + c_fmt - b_fmt), 32'd0);
        check_eq("nominal_ascii", 32'(dados_ascii), 32'h23);
        check_eq("pronto_latency", 32'(last_pronto_cyc - last_char_cyc), 32'd1);

        // Parity error on the '5'.
        snap();
        send_burst("123#456#789#", 5);
        check_eq("par_count", 32'(c_par - b_par), 32'd1);
        check_eq("par_pronto", 32'(c_pronto - b_pronto), 32'd0);
        check_eq("par_chars", 32'(c_char - b_char), 32'd11);
        check_medidas("par_hold", 12'h123, 12'h456, 12'h789);
        idle(IDLE + 50);
        check_eq("resync_db", 32'(db_estado), 32'd0);
        snap();
        send_burst("001#002#003#", -1);
        check_medidas("par_recover", 12'h001, 12'h002, 12'h003);
        check_eq("par_recover_pronto", 32'(c_pronto - b_pronto), 32'd1);

        // Framing error on char 4 with a held-low line.
        s4 = "987#654#321#";
        snap();
        for (int i = 0; i < 3; i++) send_char(7'(s4[i]), 1'b0, 1'b1);
        send_char(7'h23, 1'b0, 1'b0);
        repeat (40) @(negedge clock);
        check_eq("break_db", 32'(db_estado), 32'h9);
        idle(8);
        for (int i = 4; i < 12; i++) send_char(7'(s4[i]), 1'b0, 1'b1);
        idle(10);
        check_eq("quadro_count", 32'(c_qua - b_qua), 32'd1);
        check_eq("quadro_par", 32'(c_par - b_par), 32'd0);
        check_eq("quadro_pronto", 32'(c_pronto - b_pronto), 32'd0);
        check_medidas("quadro_hold", 12'h001, 12'h002, 12'h003);
        idle(IDLE + 50);
        send_burst(s4, -1);
        check_medidas("quadro_recover", 12'h987, 12'h654, 12'h321);

        // '#' at digit position 2.
        snap();
        send_burst("12#456#789#", -1);
        check_eq("fmt_count", 32'(c_fmt - b_fmt), 32'd1);
        check_eq("fmt_pronto", 32'(c_pronto - b_pronto), 32'd0);
        check_eq("fmt_chars", 32'(c_char - b_char), 32'd11);
        check_medidas("fmt_hold", 12'h987, 12'h654, 12'h321);
        idle(IDLE + 50);

        // Short glitch, then a burst using the A..F range (':' and '?').
        snap();
        linha = 1'b0;
        repeat (3) @(negedge clock);
        idle(100);
        check_eq("glitch_chars", 32'(c_char - b_char), 32'd0);
        check_eq("glitch_errs", 32'(c_par - b_par + c_qua - b_qua + c_fmt - b_fmt), 32'd0);
        send_burst(":?0#456#789#", -1);
        check_medidas("hexdig", 12'hAF0, 12'h456, 12'h789);
        check_eq("hexdig_ascii", 32'(dados_ascii), 32'h23);

        // Reset in the middle of char 7's data bits.
        s4 = "321#654#987#";
        for (int i = 0; i < 6; i++) send_char(7'(s4[i]), 1'b0, 1'b1);
        bit_period(1'b0);
        bit_period(1'b0);
        bit_period(1'b0);
        linha = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_medidas("midrst", 12'h000, 12'h000, 12'h000);
        check_eq("midrst_db", 32'(db_estado), 32'd0);
        reset = 1'b0;
        snap();
        idle(20);
        check_eq("rst_release_pulses",
                 32'(c_char - b_char + c_pronto - b_pronto + c_par - b_par + c_qua - b_qua + c_fmt - b_fmt),
                 32'd0);
        send_burst(s4, -1);
        check_medidas("post_rst", 12'h321, 12'h654, 12'h987);
        check_eq("post_rst_pronto", 32'(c_pronto - b_pronto), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
